// File: rtl/reg_file_operand.sv
// reg_file_operand: RV32I architectural register file plus ALU operand select.
// Two combinational read ports, one synchronous write port (rd <= ALUout).
// x0 is hard-wired to zero. x10 (a0) is exposed for observation.
// There is deliberately no write-to-read bypass. WD3 is derived from the
// operands read here, so a bypass would form a combinational loop.
module reg_file_operand #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] AD1,
  input  logic [ADDR_WIDTH-1:0] AD2,
  input  logic [ADDR_WIDTH-1:0] AD3,
  input  logic                  WE3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  ALUsrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  output logic [DATA_WIDTH-1:0] ALUop1,
  output logic [DATA_WIDTH-1:0] ALUop2,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] a0
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  // Read-side view of the whole file. Entry 0 is a constant zero and has no storage.
  logic [DATA_WIDTH-1:0] rf_view [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rf_view[gi] = '0;
      end else begin : g_store
        logic [DATA_WIDTH-1:0] q_reg;
        logic                  wr_hit;

        // The WE3 gate comes first. An unknown AD3 with WE3=0 cannot enable a write.
        assign wr_hit = WE3 && (AD3 == ADDR_WIDTH'(gi));

        // Per-register storage. Reset clears it and takes priority over a write.
        always_ff @(posedge clk) begin
          if (rst) begin
            q_reg <= '0;
          end else if (wr_hit) begin
            q_reg <= WD3;
          end
        end

        assign rf_view[gi] = q_reg;
      end
    end
  endgenerate

  // Combinational read ports and operand-2 select. Reads return the pre-edge contents.
  always_comb begin
    ALUop1 = rf_view[AD1];
    RD2    = rf_view[AD2];
    ALUop2 = ALUsrc ? ImmOp : rf_view[AD2];
  end

  // a0 (x10) is a direct tap of the register and adds no extra stage.
  assign a0 = rf_view[10];

endmodule

// File: tb/tb_reg_file_operand.sv
// tb_reg_file_operand: a table of vectors followed by hand-written sequences.
// Each applied vector pushes its expected outputs onto a scoreboard queue.
// The outputs are sampled before the next rising edge, popped and compared.
// Any write in a vector takes effect at that rising edge.
module tb_reg_file_operand;

  localparam logic [31:0] K = 32'h01010101;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  AD1, AD2, AD3;
  logic        WE3;
  logic [31:0] WD3, ImmOp;
  logic        ALUsrc;
  logic [31:0] ALUop1, ALUop2, RD2, a0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst;
    bit          we;
    logic [4:0]  ad3;
    logic [31:0] wd3;
    logic [4:0]  ad1;
    logic [4:0]  ad2;
    bit          src;
    logic [31:0] imm;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
    logic [31:0] e_rd2;
    logic [31:0] e_a0;
    bit [3:0]    chk;   // {op1, op2, rd2, a0}
  } vec_t;

  vec_t tbl [12];
  vec_t exp_q [$];

  reg_file_operand #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .WD3(WD3),
    .ALUsrc(ALUsrc), .ImmOp(ImmOp), .ALUop1(ALUop1), .ALUop2(ALUop2), .RD2(RD2), .a0(a0)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit r, bit we, logic [4:0] ad3, logic [31:0] wd3,
                              logic [4:0] ad1, logic [4:0] ad2, bit src, logic [31:0] imm,
                              logic [31:0] e1, logic [31:0] e2, logic [31:0] erd2,
                              logic [31:0] ea0, bit [3:0] chk);
    vec_t v;
    v.rst = r;
    v.we = we;
    v.ad3 = ad3;
    v.wd3 = wd3;
    v.ad1 = ad1;
    v.ad2 = ad2;
    v.src = src;
    v.imm = imm;
    v.e_op1 = e1;
    v.e_op2 = e2;
    v.e_rd2 = erd2;
    v.e_a0 = ea0;
    v.chk = chk;
    return v;
  endfunction

  task automatic cmp(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %08h expected %08h", name, idx, act, exp);
    end
  endtask

  // Drive one vector at the falling edge and queue its expected outputs.
  // Sample before the rising edge, then let that edge commit any write.
  task automatic apply(vec_t v, int idx);
    vec_t e;
    rst = v.rst;
    WE3 = v.we;
    AD3 = v.ad3;
    WD3 = v.wd3;
    AD1 = v.ad1;
    AD2 = v.ad2;
    ALUsrc = v.src;
    ImmOp = v.imm;
    exp_q.push_back(v);
    #3;
    e = exp_q.pop_front();
    if (e.chk[3]) cmp("ALUop1", idx, ALUop1, e.e_op1);
    if (e.chk[2]) cmp("ALUop2", idx, ALUop2, e.e_op2);
    if (e.chk[1]) cmp("RD2", idx, RD2, e.e_rd2);
    if (e.chk[0]) cmp("a0", idx, a0, e.e_a0);
    if (e.chk != 4'h0)
      $display("vec %0d rst=%0d we=%0d ad3=%0d wd3=%08h ad1=%0d ad2=%0d src=%0d -> op1=%08h op2=%08h rd2=%08h a0=%08h",
               idx, v.rst, v.we, v.ad3, v.wd3, v.ad1, v.ad2, v.src, ALUop1, ALUop2, RD2, a0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // The outputs in each row are the values seen before that row's edge.
    tbl[0]  = mk(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0,           0, 0, 0, 0, 4'hF);
    tbl[1]  = mk(1, 0, 0, 0,            5, 0, 0, 0,           32'hDEADBEEF, 0, 0, 0, 4'hF); // rst held, no edge yet
    tbl[2]  = mk(0, 0, 0, 0,            5, 0, 0, 0,           0, 0, 0, 0, 4'hF);
    tbl[3]  = mk(1, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0,           0, 0, 0, 0, 4'hF);            // write during reset
    tbl[4]  = mk(0, 0, 0, 0,            5, 0, 1, 32'h55,      0, 32'h55, 0, 0, 4'hF);       // write dropped
    tbl[5]  = mk(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0,           0, 0, 0, 0, 4'hF);
    tbl[6]  = mk(0, 0, 0, 0,            0, 0, 0, 0,           0, 0, 0, 0, 4'hF);            // x0 still 0
    tbl[7]  = mk(0, 1, 7, 32'h12345678, 7, 0, 0, 0,           0, 0, 0, 0, 4'hF);            // old value
    tbl[8]  = mk(0, 0, 0, 0,            7, 7, 0, 0,           32'h12345678, 32'h12345678, 32'h12345678, 0, 4'hF);
    tbl[9]  = mk(0, 1, 3, 32'h10,       7, 0, 0, 0,           32'h12345678, 0, 0, 0, 4'hF);
    tbl[10] = mk(0, 0, 0, 0,            7, 3, 0, 32'hFFFFFFFC, 32'h12345678, 32'h10, 32'h10, 0, 4'hF);
    tbl[11] = mk(0, 0, 0, 0,            7, 3, 1, 32'hFFFFFFFC, 32'h12345678, 32'hFFFFFFFC, 32'h10, 0, 4'hF);

    // Initial reset.
    rst = 1'b1; WE3 = 1'b0; AD1 = '0; AD2 = '0; AD3 = '0; WD3 = '0; ALUsrc = 1'b0; ImmOp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 12; i++) apply(tbl[i], i);

    // a0 tracking: x10=5, then ALUout = a0+1 once per edge.
    apply(mk(0, 1, 10, 32'd5, 10, 0, 0, 0, 0, 0, 0, 0, 4'hF), 100);
    for (int k = 0; k < 5; k++)
      apply(mk(0, 1, 10, 32'(5 + k + 1), 10, 0, 0, 0, 32'(5 + k), 0, 0, 32'(5 + k), 4'b1001), 101 + k);

    // Sweep: reg[i] = i*0x01010101.
    for (int i = 1; i < 32; i++)
      apply(mk(0, 1, 5'(i), 32'(i) * K, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0), 200 + i);
    for (int i = 0; i < 32; i++)
      apply(mk(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 32'(i) * K, 32'(31 - i) * K,
               32'(31 - i) * K, 32'd10 * K, 4'hF), 300 + i);
    apply(mk(0, 0, 0, 0, 17, 17, 0, 0, 32'd17 * K, 32'd17 * K, 32'd17 * K, 32'd10 * K, 4'hF), 400);

    // A mid-program reset clears the file in one edge.
    apply(mk(1, 1, 31, 32'hCAFEF00D, 31, 10, 0, 0, 32'd31 * K, 32'd10 * K, 32'd10 * K, 32'd10 * K, 4'hF), 500);
    apply(mk(0, 0, 0, 0, 31, 10, 1, 32'h7, 0, 32'h7, 0, 0, 4'hF), 501);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
